// File: rtl/wave_cacher_pkg.sv
// wave_cacher_pkg
//   Shared constants and types for the wave cacher and its neighbours.
//   Holds the SRAM bus widths, the ring-buffer placement in SRAM (also
//   consumed by the burst-read address generator) and the hold-state
//   encoding used around the SRAM controller's Cacher write slot.
package wave_cacher_pkg;

  localparam int BW_DATA   = 16;
  localparam int BW_ADDR   = 18;
  localparam int FIFO_LOG2 = 3;

  // Ring of 4096 words starting at BASE_ADDR. The low RING_LOG2 bits of
  // BASE_ADDR are zero, so ring addresses are formed by OR, not by adding.
  localparam int                 RING_LOG2 = 12;
  localparam int                 RING_LEN  = 1 << RING_LOG2;
  localparam logic [BW_ADDR-1:0] BASE_ADDR = 18'h3F000;

  // IDLE: presentation registers follow the FIFO every cycle.
  // H1  : the controller is capturing data; the commit happens as H1 ends.
  // H2  : presentation reloads with the next sample as H2 ends.
  typedef enum logic [1:0] {
    HOLD_IDLE = 2'd0,
    HOLD_H1   = 2'd1,
    HOLD_H2   = 2'd2
  } holdState_t;

endpackage

// File: rtl/cacher_fifo.sv
// cacher_fifo
//   Small synchronous show-ahead FIFO holding audio samples until the
//   SRAM controller's next Cacher write slot.
// Ports:
//   Clock, Reset : system clock, asynchronous active-high reset
//   push         : write din this edge (accepted if not full, or if a pop
//                  happens on the same edge)
//   pop          : discard the head entry this edge (ignored when empty)
//   din          : sample to write
//   dout         : current head entry (valid while not empty)
//   level        : current occupancy, 0 .. 2**FIFO_LOG2
//   full, empty  : occupancy flags
module cacher_fifo #(
  parameter int FIFO_LOG2 = 3,
  parameter int DATA_W    = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic [FIFO_LOG2:0]  level,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [FIFO_LOG2-1:0] rdPtr;
  logic [FIFO_LOG2-1:0] wrPtr;
  logic                 doPush;
  logic                 doPop;

  assign full  = (level == (FIFO_LOG2+1)'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot on the same edge, so a push at full is still taken
  // when it coincides with a pop.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  assign dout = mem[rdPtr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge Clock) begin
    if (doPush) begin
      mem[wrPtr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; the pointers wrap naturally.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + FIFO_LOG2'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + FIFO_LOG2'(1);
      end
      case ({doPush, doPop})
        2'b10:   level <= level + (FIFO_LOG2+1)'(1);
        2'b01:   level <= level - (FIFO_LOG2+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/wave_cacher.sv
// wave_cacher
//   Buffers incoming audio samples and feeds the SRAM controller's single
//   per-frame wave-write slot (the Cacher port). Samples are written into
//   a ring of 2**RING_LOG2 words at BASE_ADDR; HeadAddr tells the
//   burst-read/spectrum path where the newest committed sample lives.
// Ports:
//   Clock, Reset  : system clock, asynchronous active-high reset
//   SampleValid   : one-cycle strobe, SampleIn is valid
//   SampleIn      : audio sample
//   WrSlot        : controller selects the Cacher address this cycle and
//                   captures the data the following cycle
//   WrAddrCacher  : registered SRAM write address for the controller
//   DataCacher    : registered SRAM write data for the controller
//   HeadAddr      : address of the most recently committed fresh sample
//   FifoLevel     : current sample FIFO occupancy
//   Overflow      : sticky, a sample was dropped because the FIFO was full
//   ClearOverflow : synchronous clear of Overflow (a same-edge drop wins)
module wave_cacher #(
  parameter int                 BW_DATA   = wave_cacher_pkg::BW_DATA,
  parameter int                 BW_ADDR   = wave_cacher_pkg::BW_ADDR,
  parameter int                 FIFO_LOG2 = wave_cacher_pkg::FIFO_LOG2,
  parameter int                 RING_LOG2 = wave_cacher_pkg::RING_LOG2,
  parameter logic [BW_ADDR-1:0] BASE_ADDR = wave_cacher_pkg::BASE_ADDR
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 SampleValid,
  input  logic [BW_DATA-1:0]   SampleIn,
  input  logic                 WrSlot,
  output logic [BW_ADDR-1:0]   WrAddrCacher,
  output logic [BW_DATA-1:0]   DataCacher,
  output logic [BW_ADDR-1:0]   HeadAddr,
  output logic [FIFO_LOG2:0]   FifoLevel,
  output logic                 Overflow,
  input  logic                 ClearOverflow
);

  import wave_cacher_pkg::*;

  holdState_t           holdState;
  logic                 fresh;
  logic [RING_LOG2-1:0] wrPtr;
  logic [RING_LOG2-1:0] prevPtr;
  logic [BW_DATA-1:0]   lastData;
  logic [BW_DATA-1:0]   fifoHead;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic                 commitNow;
  logic                 dropNow;
  logic                 loadPres;
  logic [BW_ADDR-1:0]   freshAddr;
  logic [BW_ADDR-1:0]   rewriteAddr;

  cacher_fifo #(
    .FIFO_LOG2 (FIFO_LOG2),
    .DATA_W    (BW_DATA)
  ) sampleFifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (SampleValid),
    .pop   (commitNow),
    .din   (SampleIn),
    .dout  (fifoHead),
    .level (FifoLevel),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  // The ring base has zero low bits, so OR-ing the pointer in is enough.
  // Before the first commit wrPtr is 0, so prevPtr is the last ring word
  // and the idle rewrite goes there with zero data.
  assign prevPtr     = wrPtr - RING_LOG2'(1);
  assign freshAddr   = BASE_ADDR | BW_ADDR'(wrPtr);
  assign rewriteAddr = BASE_ADDR | BW_ADDR'(prevPtr);

  // The presented word is committed as H1 ends, after the controller has
  // taken both address and data. A fresh word implies a non-empty FIFO.
  assign commitNow = (holdState == HOLD_H1) && fresh;
  assign dropNow   = SampleValid && fifoFull && !commitNow;

  // The outputs freeze at the edge ending the WrSlot cycle and the edge
  // ending H1, so they stay put across address select and data capture.
  assign loadPres = ((holdState == HOLD_IDLE) && !WrSlot) ||
                    (holdState == HOLD_H2);

  // Hold sequencing, presentation registers, commit and overflow tracking.
  // An empty FIFO presents a rewrite of the last committed word because
  // the controller writes every frame whether or not we have new data.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      holdState    <= HOLD_IDLE;
      WrAddrCacher <= BASE_ADDR;
      DataCacher   <= '0;
      fresh        <= 1'b0;
      HeadAddr     <= BASE_ADDR;
      lastData     <= '0;
      wrPtr        <= '0;
      Overflow     <= 1'b0;
    end else begin
      case (holdState)
        HOLD_IDLE: if (WrSlot) holdState <= HOLD_H1;
        HOLD_H1:   holdState <= HOLD_H2;
        HOLD_H2:   holdState <= HOLD_IDLE;
        default:   holdState <= HOLD_IDLE;
      endcase

      if (loadPres) begin
        if (!fifoEmpty) begin
          WrAddrCacher <= freshAddr;
          DataCacher   <= fifoHead;
          fresh        <= 1'b1;
        end else begin
          WrAddrCacher <= rewriteAddr;
          DataCacher   <= lastData;
          fresh        <= 1'b0;
        end
      end

      if (commitNow) begin
        HeadAddr <= WrAddrCacher;
        lastData <= DataCacher;
        wrPtr    <= wrPtr + RING_LOG2'(1);
      end

      if (dropNow) begin
        Overflow <= 1'b1;
      end else if (ClearOverflow) begin
        Overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wave_cacher.sv
// tb_wave_cacher
//   Self-checking bench for wave_cacher. A queue-based reference model
//   tracks the sample FIFO, ring index, last committed sample, head
//   address and overflow flag; directed sequences, a table of overflow
//   vectors and randomized traffic are all compared against it.
module tb_wave_cacher;

  localparam logic [17:0] BASE  = 18'h3F000;
  localparam int          RING  = 4096;
  localparam int          DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        SampleValid;
  logic [15:0] SampleIn;
  logic        WrSlot;
  logic        ClearOverflow;
  logic [17:0] WrAddrCacher;
  logic [15:0] DataCacher;
  logic [17:0] HeadAddr;
  logic [3:0]  FifoLevel;
  logic        Overflow;

  wave_cacher dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .SampleValid   (SampleValid),
    .SampleIn      (SampleIn),
    .WrSlot        (WrSlot),
    .WrAddrCacher  (WrAddrCacher),
    .DataCacher    (DataCacher),
    .HeadAddr      (HeadAddr),
    .FifoLevel     (FifoLevel),
    .Overflow      (Overflow),
    .ClearOverflow (ClearOverflow)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] mQ[$];
  int          mWrIdx;
  logic [15:0] mLast;
  logic [17:0] mHead;
  logic        mOvf;
  int          mPhase;   // 0 idle, 1 slot taken (commit next), 2 after commit

  typedef struct {
    bit          sv;
    logic [15:0] sin;
    bit          clr;
    int          expLevel;
    bit          expOvf;
  } vec_t;

  vec_t tbl[13];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    mWrIdx = 0;
    mLast  = 16'h0000;
    mHead  = BASE;
    mOvf   = 1'b0;
    mPhase = 0;
  endtask

  // What the cacher should be presenting given the model's current state.
  task automatic expectPres(output logic [17:0] a, output logic [15:0] d);
    if (mQ.size() > 0) begin
      a = BASE | 18'(mWrIdx);
      d = mQ[0];
    end else begin
      a = BASE | 18'((mWrIdx + RING - 1) % RING);
      d = mLast;
    end
  endtask

  // One clock edge: drive, advance the model, check the slow outputs.
  task automatic applyStimulus(input bit sv, input logic [15:0] sin,
                               input bit slot, input bit clr);
    bit drop;
    drop          = 1'b0;
    SampleValid   = sv;
    SampleIn      = sin;
    WrSlot        = slot;
    ClearOverflow = clr;
    @(posedge Clock);
    if (mPhase == 1 && mQ.size() > 0) begin
      mHead  = BASE | 18'(mWrIdx);
      mLast  = mQ.pop_front();
      mWrIdx = (mWrIdx + 1) % RING;
    end
    if (sv) begin
      if (mQ.size() < DEPTH) mQ.push_back(sin);
      else drop = 1'b1;
    end
    if (drop) mOvf = 1'b1;
    else if (clr) mOvf = 1'b0;
    if (mPhase == 0 && slot) mPhase = 1;
    else if (mPhase == 1) mPhase = 2;
    else if (mPhase == 2) mPhase = 0;
    #1;
    SampleValid   = 1'b0;
    WrSlot        = 1'b0;
    ClearOverflow = 1'b0;
    checkOutput("level", 32'(FifoLevel), 32'(mQ.size()));
    checkOutput("overflow", 32'(Overflow), 32'(mOvf));
    checkOutput("head", 32'(HeadAddr), 32'(mHead));
  endtask

  // A full write-slot window. Two quiet edges first so the presentation
  // reflects the current queue; the optional push lands on the commit edge.
  task automatic doSlot(input bit pushAtCommit, input logic [15:0] commitSample,
                        input string tag, output logic [17:0] slotAddr,
                        output logic [15:0] slotData);
    logic [17:0] eA;
    logic [15:0] eD;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    expectPres(eA, eD);
    checkOutput({tag, " slot addr"}, 32'(WrAddrCacher), 32'(eA));
    checkOutput({tag, " slot data"}, 32'(DataCacher), 32'(eD));
    slotAddr = WrAddrCacher;
    slotData = DataCacher;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput({tag, " h1 addr"}, 32'(WrAddrCacher), 32'(eA));
    checkOutput({tag, " h1 data"}, 32'(DataCacher), 32'(eD));
    applyStimulus(pushAtCommit, commitSample, 1'b0, 1'b0);
    checkOutput({tag, " h2 addr"}, 32'(WrAddrCacher), 32'(eA));
    checkOutput({tag, " h2 data"}, 32'(DataCacher), 32'(eD));
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    expectPres(eA, eD);
    checkOutput({tag, " next addr"}, 32'(WrAddrCacher), 32'(eA));
    checkOutput({tag, " next data"}, 32'(DataCacher), 32'(eD));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " addr"}, 32'(WrAddrCacher), 32'(BASE));
    checkOutput({tag, " data"}, 32'(DataCacher), 32'h0);
    checkOutput({tag, " head"}, 32'(HeadAddr), 32'(BASE));
    checkOutput({tag, " level"}, 32'(FifoLevel), 32'h0);
    checkOutput({tag, " overflow"}, 32'(Overflow), 32'h0);
  endtask

  initial begin
    logic [17:0] a;
    logic [15:0] d;
    logic [15:0] expD;
    int          idle;
    int          rate;

    for (int i = 0; i < 9; i++) begin
      tbl[i] = '{1'b1, 16'hB000 + 16'(i), 1'b0, (i < 8) ? i + 1 : 8, (i == 8)};
    end
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 8, 1'b0};
    tbl[10] = '{1'b1, 16'hB00A, 1'b1, 8, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 8, 1'b0};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 8, 1'b0};

    SampleValid   = 1'b0;
    SampleIn      = 16'h0;
    WrSlot        = 1'b0;
    ClearOverflow = 1'b0;
    Reset         = 1'b1;
    modelReset();
    repeat (3) @(posedge Clock);
    #1;
    checkResetValues("reset");
    Reset = 1'b0;

    // Empty FIFO: idempotent rewrite of the last ring word with zero data.
    doSlot(1'b0, 16'h0, "empty", a, d);
    checkOutput("empty addr", 32'(a), 32'h3FFFF);
    checkOutput("empty data", 32'(d), 32'h0);
    checkOutput("empty head", 32'(HeadAddr), 32'h3F000);

    // Single fresh sample.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    doSlot(1'b0, 16'h0, "first", a, d);
    checkOutput("first addr", 32'(a), 32'h3F000);
    checkOutput("first data", 32'(d), 32'h1234);
    checkOutput("first head", 32'(HeadAddr), 32'h3F000);
    checkOutput("first level", 32'(FifoLevel), 32'h0);

    // Push during H1 must not disturb the word being written.
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
    doSlot(1'b1, 16'hAAAA, "midhold", a, d);
    checkOutput("midhold data", 32'(d), 32'h5555);
    checkOutput("midhold next addr", 32'(WrAddrCacher), 32'h3F002);
    checkOutput("midhold next data", 32'(DataCacher), 32'hAAAA);
    doSlot(1'b0, 16'h0, "drainAAAA", a, d);
    checkOutput("drainAAAA head", 32'(HeadAddr), 32'h3F002);

    // Fill past full, with clear/drop interactions, from the vector table.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].sv, tbl[i].sin, 1'b0, tbl[i].clr);
      checkOutput($sformatf("tbl%0d level", i), 32'(FifoLevel), 32'(tbl[i].expLevel));
      checkOutput($sformatf("tbl%0d overflow", i), 32'(Overflow), 32'(tbl[i].expOvf));
    end

    // Full FIFO, push on the commit edge: accepted without overflow.
    doSlot(1'b1, 16'hC0DE, "fullcommit", a, d);
    checkOutput("fullcommit data", 32'(d), 32'hB000);
    checkOutput("fullcommit level", 32'(FifoLevel), 32'h8);
    checkOutput("fullcommit overflow", 32'(Overflow), 32'h0);
    for (int k = 0; k < 8; k++) begin
      expD = (k < 7) ? 16'hB001 + 16'(k) : 16'hC0DE;
      doSlot(1'b0, 16'h0, "drain", a, d);
      checkOutput($sformatf("drain%0d data", k), 32'(d), 32'(expD));
    end

    // Reset while the controller is mid-hold.
    applyStimulus(1'b1, 16'h1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    Reset = 1'b1;
    #1;
    checkResetValues("midreset");
    modelReset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    doSlot(1'b0, 16'h0, "postreset", a, d);
    checkOutput("postreset addr", 32'(a), 32'h3FFFF);
    checkOutput("postreset data", 32'(d), 32'h0);

    // Randomized traffic with varying push density and sporadic clears.
    for (int w = 0; w < 40; w++) begin
      idle = $urandom_range(20, 40);
      rate = $urandom_range(1, 8);
      for (int c = 0; c < idle; c++) begin
        applyStimulus($urandom_range(1, rate) == 1, 16'($urandom), 1'b0,
                      $urandom_range(0, 15) == 0);
      end
      doSlot($urandom_range(0, 1) == 1, 16'($urandom), "rand", a, d);
    end

    // Ring wrap: 4096 commits from a fresh start, then one more.
    // Slots come closer together here than the controller would issue them.
    Reset = 1'b1;
    #1;
    modelReset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < RING; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
      doSlot(1'b0, 16'h0, "wrap", a, d);
      if (i == 0) checkOutput("wrap first addr", 32'(a), 32'h3F000);
      if (i == RING - 1) begin
        checkOutput("wrap last addr", 32'(a), 32'h3FFFF);
        checkOutput("wrap last head", 32'(HeadAddr), 32'h3FFFF);
      end
    end
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0);
    doSlot(1'b0, 16'h0, "wrapped", a, d);
    checkOutput("wrapped addr", 32'(a), 32'h3F000);
    checkOutput("wrapped data", 32'(d), 32'hBEEF);
    checkOutput("wrapped head", 32'(HeadAddr), 32'h3F000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
